// File: rtl/result_collector.sv
// result_collector: write-back stage that round-robin arbitrates EU result streams onto one RF write port.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   eu_to_rc_valid_i         per-EU result valid
//   rc_to_eu_ready_o         per-EU result accepted (only the granted EU can see 1)
//   eu_to_rc_tag_i           per-EU instruction id {tag, wid}
//   eu_to_rc_act_mask_i      per-EU active-thread mask
//   eu_to_rc_dst_i           per-EU destination register index
//   eu_to_rc_data_i          per-EU warp result, thread i at [i*RegWidth +: RegWidth]
//   rc_to_rf_valid_o         register-file write request (entry full)
//   rf_to_rc_ready_i         register file accepts the write
//   rc_to_rf_wid_o/dst_o/mask_o/data_o   write fields from the output entry
//   rc_to_disp_valid_o       tag-release strobe, one per completed write
//   rc_to_disp_wid_o/tag_o   warp and tag being released
//   perf_retired_o           per-EU accepted-result counters (RC_PERF_COUNTERS_EN only)
//   perf_stall_o             cycles stalled on RF backpressure (RC_PERF_COUNTERS_EN only)
//
// Optional feature macro: RC_PERF_COUNTERS_EN
module result_collector #(
    parameter int NumEus      = 2,
    parameter int NumTags     = 8,
    parameter int RegWidth    = 32,
    parameter int WarpWidth   = 4,
    parameter int NumWarps    = 8,
    parameter int RegIdxWidth = 8,
    localparam int TagWidth   = $clog2(NumTags),
    localparam int WidWidth   = NumWarps > 1 ? $clog2(NumWarps) : 1,
    localparam int EuIdxWidth = NumEus > 1 ? $clog2(NumEus) : 1,
    localparam int IidWidth   = TagWidth + WidWidth,
    localparam int DataWidth  = RegWidth * WarpWidth
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumEus-1:0]               eu_to_rc_valid_i,
    output logic [NumEus-1:0]               rc_to_eu_ready_o,
    input  logic [NumEus*IidWidth-1:0]      eu_to_rc_tag_i,
    input  logic [NumEus*WarpWidth-1:0]     eu_to_rc_act_mask_i,
    input  logic [NumEus*RegIdxWidth-1:0]   eu_to_rc_dst_i,
    input  logic [NumEus*DataWidth-1:0]     eu_to_rc_data_i,
    output logic                            rc_to_rf_valid_o,
    input  logic                            rf_to_rc_ready_i,
    output logic [WidWidth-1:0]             rc_to_rf_wid_o,
    output logic [RegIdxWidth-1:0]          rc_to_rf_dst_o,
    output logic [WarpWidth-1:0]            rc_to_rf_mask_o,
    output logic [DataWidth-1:0]            rc_to_rf_data_o,
    output logic                            rc_to_disp_valid_o,
    output logic [WidWidth-1:0]             rc_to_disp_wid_o,
    output logic [TagWidth-1:0]             rc_to_disp_tag_o
`ifdef RC_PERF_COUNTERS_EN
    ,
    output logic [NumEus*32-1:0]            perf_retired_o,
    output logic [31:0]                     perf_stall_o
`endif
);
    localparam logic [EuIdxWidth:0] EusW = (EuIdxWidth + 1)'(NumEus);

    logic                   r_full;
    logic [EuIdxWidth-1:0]  r_rr;
    logic [IidWidth-1:0]    r_iid;
    logic [RegIdxWidth-1:0] r_dst;
    logic [WarpWidth-1:0]   r_mask;
    logic [DataWidth-1:0]   r_data;

    logic                   w_accept_en;
    logic                   w_any;
    logic                   w_eu_fire;
    logic                   w_rf_fire;
    logic [NumEus-1:0]      w_rot;
    logic [EuIdxWidth-1:0]  w_pos;
    logic [EuIdxWidth:0]    w_sum;
    logic [EuIdxWidth:0]    w_inc;
    logic [EuIdxWidth-1:0]  w_grant;
    logic [EuIdxWidth-1:0]  w_rr_next;
    logic [IidWidth-1:0]    w_sel_iid;
    logic [RegIdxWidth-1:0] w_sel_dst;
    logic [WarpWidth-1:0]   w_sel_mask;
    logic [DataWidth-1:0]   w_sel_data;

    assign w_accept_en = !r_full || rf_to_rc_ready_i;
    assign w_any       = |eu_to_rc_valid_i;
    assign w_eu_fire   = w_any && w_accept_en;
    assign w_rf_fire   = r_full && rf_to_rc_ready_i;

    // Rotate valids so that bit 0 is the EU at the round-robin pointer.
    assign w_rot = NumEus'({eu_to_rc_valid_i, eu_to_rc_valid_i} >> r_rr);

    always_comb begin
        w_pos = '0;
        for (int i = NumEus - 1; i >= 0; i--)
            if (w_rot[i]) w_pos = EuIdxWidth'(i);
    end

    assign w_sum     = {1'b0, r_rr} + {1'b0, w_pos};
    assign w_grant   = (w_sum >= EusW) ? EuIdxWidth'(w_sum - EusW) : EuIdxWidth'(w_sum);
    assign w_inc     = {1'b0, w_grant} + 1'b1;
    assign w_rr_next = (w_inc >= EusW) ? EuIdxWidth'(w_inc - EusW) : EuIdxWidth'(w_inc);

    always_comb begin
        rc_to_eu_ready_o = '0;
        w_sel_iid        = '0;
        w_sel_dst        = '0;
        w_sel_mask       = '0;
        w_sel_data       = '0;
        for (int i = 0; i < NumEus; i++) begin
            if (EuIdxWidth'(i) == w_grant) begin
                rc_to_eu_ready_o[i] = w_any && w_accept_en;
                w_sel_iid           = eu_to_rc_tag_i[i*IidWidth +: IidWidth];
                w_sel_dst           = eu_to_rc_dst_i[i*RegIdxWidth +: RegIdxWidth];
                w_sel_mask          = eu_to_rc_act_mask_i[i*WarpWidth +: WarpWidth];
                w_sel_data          = eu_to_rc_data_i[i*DataWidth +: DataWidth];
            end
        end
    end

    // A new accept while the RF drains the old entry keeps full set (no bubble).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_full <= 1'b0;
            r_rr   <= '0;
            r_iid  <= '0;
            r_dst  <= '0;
            r_mask <= '0;
            r_data <= '0;
        end else begin
            r_full <= w_eu_fire || (r_full && !rf_to_rc_ready_i);
            if (w_eu_fire) begin
                r_rr   <= w_rr_next;
                r_iid  <= w_sel_iid;
                r_dst  <= w_sel_dst;
                r_mask <= w_sel_mask;
                r_data <= w_sel_data;
            end
        end
    end

    assign rc_to_rf_valid_o   = r_full;
    assign rc_to_rf_wid_o     = r_iid[WidWidth-1:0];
    assign rc_to_rf_dst_o     = r_dst;
    assign rc_to_rf_mask_o    = r_mask;
    assign rc_to_rf_data_o    = r_data;
    assign rc_to_disp_valid_o = w_rf_fire;
    assign rc_to_disp_wid_o   = r_iid[WidWidth-1:0];
    assign rc_to_disp_tag_o   = r_iid[IidWidth-1:WidWidth];

`ifdef RC_PERF_COUNTERS_EN
    logic [NumEus*32-1:0] r_retired;
    logic [31:0]          r_stall;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_retired <= '0;
            r_stall   <= '0;
        end else begin
            if (r_full && !rf_to_rc_ready_i)
                r_stall <= r_stall + 32'd1;
            for (int i = 0; i < NumEus; i++)
                if (w_eu_fire && EuIdxWidth'(i) == w_grant)
                    r_retired[i*32 +: 32] <= r_retired[i*32 +: 32] + 32'd1;
        end
    end

    assign perf_retired_o = r_retired;
    assign perf_stall_o   = r_stall;
`endif
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: randomized scoreboard bench for result_collector.
module tb_result_collector;
    localparam int NE  = 2;
    localparam int RW  = 32;
    localparam int WW  = 4;
    localparam int NW  = 8;
    localparam int RI  = 8;
    localparam int TW  = 3;
    localparam int WDW = 3;
    localparam int IW  = TW + WDW;
    localparam int DW  = RW * WW;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NE-1:0]     eu_valid = '0;
    logic [NE-1:0]     eu_ready;
    logic [NE*IW-1:0]  eu_tag = '0;
    logic [NE*WW-1:0]  eu_mask = '0;
    logic [NE*RI-1:0]  eu_dst = '0;
    logic [NE*DW-1:0]  eu_data = '0;
    logic              rf_valid;
    logic              rf_ready = 1'b0;
    logic [WDW-1:0]    rf_wid;
    logic [RI-1:0]     rf_dst;
    logic [WW-1:0]     rf_mask;
    logic [DW-1:0]     rf_data;
    logic              disp_valid;
    logic [WDW-1:0]    disp_wid;
    logic [TW-1:0]     disp_tag;
`ifdef RC_PERF_COUNTERS_EN
    logic [NE*32-1:0]  perf_retired;
    logic [31:0]       perf_stall;
`endif

    result_collector dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .eu_to_rc_valid_i    (eu_valid),
        .rc_to_eu_ready_o    (eu_ready),
        .eu_to_rc_tag_i      (eu_tag),
        .eu_to_rc_act_mask_i (eu_mask),
        .eu_to_rc_dst_i      (eu_dst),
        .eu_to_rc_data_i     (eu_data),
        .rc_to_rf_valid_o    (rf_valid),
        .rf_to_rc_ready_i    (rf_ready),
        .rc_to_rf_wid_o      (rf_wid),
        .rc_to_rf_dst_o      (rf_dst),
        .rc_to_rf_mask_o     (rf_mask),
        .rc_to_rf_data_o     (rf_data),
        .rc_to_disp_valid_o  (disp_valid),
        .rc_to_disp_wid_o    (disp_wid),
        .rc_to_disp_tag_o    (disp_tag)
`ifdef RC_PERF_COUNTERS_EN
        ,
        .perf_retired_o      (perf_retired),
        .perf_stall_o        (perf_stall)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          iid;
        int          dst;
        int          mask;
        logic [DW-1:0] data;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   rr_m = 0;
    bit   full_m = 1'b0;
    int   retired_m[NE];
    int   stall_m = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock of stimulus plus the reference model's view of that cycle.
    task automatic step(input logic [NE-1:0] v, input bit rdy, input bit zmask, input bit rst, input bit dir);
        int g;
        int idx;
        bit acc;
        logic [NE-1:0] exp_rdy;
        res_t r;
        @(posedge clk_i);
        #1;
        rst_ni   = !rst;
        eu_valid = v;
        rf_ready = rdy;
        for (int e = 0; e < NE; e++) begin
            eu_tag[e*IW +: IW]  = IW'($urandom);
            eu_dst[e*RI +: RI]  = RI'($urandom);
            eu_mask[e*WW +: WW] = zmask ? '0 : WW'($urandom);
            for (int t = 0; t < WW; t++) eu_data[e*DW + t*RW +: RW] = $urandom;
        end
        if (dir) begin
            eu_tag[0 +: IW]  = IW'(11);
            eu_dst[0 +: RI]  = RI'(5);
            eu_mask[0 +: WW] = 4'b1011;
            eu_data[0 +: DW] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        end
        #1;
        acc = !full_m || rdy;
        g = -1;
        for (int k = 0; k < NE; k++) begin
            idx = (rr_m + k) % NE;
            if (g < 0 && ((v >> idx) & NE'(1)) != '0) g = idx;
        end
        exp_rdy = (acc && g >= 0) ? NE'(1) << g : '0;
        chk("eu_ready", DW'(eu_ready), DW'(exp_rdy));
        chk("rf_valid", DW'(rf_valid), DW'(full_m));
        if (rst) begin
            full_m = 1'b0;
            rr_m   = 0;
            stall_m = 0;
            foreach (retired_m[e]) retired_m[e] = 0;
            exp_q.delete();
        end else begin
            if (full_m && !rdy) stall_m++;
            if (acc && g >= 0) begin
                r.iid  = int'(eu_tag[g*IW +: IW]);
                r.dst  = int'(eu_dst[g*RI +: RI]);
                r.mask = int'(eu_mask[g*WW +: WW]);
                r.data = eu_data[g*DW +: DW];
                exp_q.push_back(r);
                retired_m[g]++;
                rr_m   = (g + 1) % NE;
                full_m = 1'b1;
            end else if (full_m && rdy) begin
                full_m = 1'b0;
            end
        end
    endtask

    // Monitor: every RF handshake must match the oldest accepted result and release its tag.
    initial begin
        res_t r;
        forever begin
            @(negedge clk_i);
            if (rst_ni && rf_valid && rf_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL rf_write: got write dst=%0h, expected no write", rf_dst);
                end else begin
                    r = exp_q.pop_front();
                    chk("rf_dst", DW'(rf_dst), DW'(r.dst));
                    chk("rf_mask", DW'(rf_mask), DW'(r.mask));
                    chk("rf_data", rf_data, r.data);
                    chk("rf_wid", DW'(rf_wid), DW'(r.iid % NW));
                    chk("disp_valid", DW'(disp_valid), DW'(1));
                    chk("disp_wid", DW'(disp_wid), DW'(r.iid % NW));
                    chk("disp_tag", DW'(disp_tag), DW'(r.iid / NW));
                end
            end else begin
                chk("disp_idle", DW'(disp_valid), DW'(0));
            end
        end
    end

    initial begin
        foreach (retired_m[e]) retired_m[e] = 0;
        step(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_data", rf_data, '0);
        chk("reset_dst", DW'(rf_dst), DW'(0));
        chk("reset_mask", DW'(rf_mask), DW'(0));
        chk("reset_wid", DW'(rf_wid), DW'(0));
        step(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) step(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (400)
            step(NE'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef RC_PERF_COUNTERS_EN
        for (int e = 0; e < NE; e++)
            chk("perf_retired", DW'(perf_retired[e*32 +: 32]), DW'(retired_m[e]));
        chk("perf_stall", DW'(perf_stall), DW'(stall_m));
`endif
        chk("queue_drained", DW'(exp_q.size()), DW'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/result_collector.md
# result_collector

Write-back stage behind the execution units (integer unit and peers). Accepts completed warp results over per-unit valid/ready streams, arbitrates them round-robin onto the single register-file write port through a one-entry output register, and emits a tag-release strobe to the dispatcher on every completed write. One instance per compute unit.

## Interface
- `NumEus`, 2: number of execution-unit result streams
- `NumTags`, 8: inflight instructions per warp
- `RegWidth`, 32: register width in bits
- `WarpWidth`, 4: threads per warp
- `NumWarps`, 8: warps per compute unit
- `RegIdxWidth`, 8: register index width
- Derived, do not override: `TagWidth = $clog2(NumTags)`, `WidWidth = NumWarps>1 ? $clog2(NumWarps) : 1`, `EuIdxWidth = NumEus>1 ? $clog2(NumEus) : 1`, iid = `TagWidth+WidWidth` bits, `iid[WidWidth-1:0]` is the warp id

- `clk_i` in 1: clock
- `rst_ni` in 1: reset, synchronous, active-low
- `eu_to_rc_valid_i` in NumEus: result valid per EU
- `rc_to_eu_ready_o` out NumEus: result accepted per EU
- `eu_to_rc_tag_i` in NumEus×iid: instruction id
- `eu_to_rc_act_mask_i` in NumEus×WarpWidth: active threads
- `eu_to_rc_dst_i` in NumEus×RegIdxWidth: destination register
- `eu_to_rc_data_i` in NumEus×(RegWidth·WarpWidth): result, thread i in bits [i·RegWidth +: RegWidth]
- `rc_to_rf_valid_o` out 1: write request
- `rf_to_rc_ready_i` in 1: register file accepts write
- `rc_to_rf_wid_o` out WidWidth: warp id
- `rc_to_rf_dst_o` out RegIdxWidth: register index
- `rc_to_rf_mask_o` out WarpWidth: per-thread write enable
- `rc_to_rf_data_o` out RegWidth·WarpWidth: write data
- `rc_to_disp_valid_o` out 1: tag-release strobe
- `rc_to_disp_wid_o` out WidWidth: warp of released tag
- `rc_to_disp_tag_o` out TagWidth: released tag (`iid[TagWidth+WidWidth-1:WidWidth]`)

## Operation
- Output register: one entry {iid, dst, mask, data}, `full` flag.
- `accept_en = !full || rf_to_rc_ready_i`.
- Arbiter: round-robin pointer `rr_q`; grant = first valid EU at index ≥ `rr_q`, wrapping. Only the granted EU sees `rc_to_eu_ready_o = accept_en`; all others 0.
- On EU handshake: load entry, set `full`; `rr_q <= grant+1` (wraps NumEus-1 → 0). No handshake → `rr_q` unchanged.
- On RF handshake without new accept: clear `full`. Simultaneous RF handshake and EU accept: entry replaced, `full` stays 1 (back-to-back, no bubble).
- `rc_to_rf_valid_o = full`; wid/dst/mask/data driven from entry. Fields stable while valid && !ready.
- Tag release: `rc_to_disp_valid_o = full && rf_to_rc_ready_i`; wid/tag from entry. Exactly one release per written result.
- All-zero act mask: still registered, written with mask 0, tag released.
- No `rc_to_eu_ready_o` depends combinationally on its own `eu_to_rc_valid_i` except through the arbiter grant.

## Timing
- Latency: EU handshake at cycle N → `rc_to_rf_valid_o` at N+1.
- Throughput: one result per cycle while `rf_to_rc_ready_i` = 1.
- Reset (sync, `rst_ni`=0 at a clock edge): `full`=0, `rr_q`=0, counters 0. Outputs after reset: `rc_to_rf_valid_o`=0, `rc_to_disp_valid_o`=0, `rc_to_eu_ready_o` = grant-one-hot gated by valids (entry empty), data fields 0.
- Reset mid-transfer drops the held entry; no release issued for it.

## Configuration
- `RC_PERF_COUNTERS_EN` defined: adds outputs `perf_retired_o` (NumEus×32, per-EU accepted results) and `perf_stall_o` (32, cycles with `full && !rf_to_rc_ready_i`); 32-bit wrap-around counters, cleared on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Single result: EU0 valid, tag=0x0B, dst=5, mask=4'b1011, data=0x…; RF ready → RF write at N+1 with same fields, release wid=3, tag=1.
- Contention: EU0 and EU1 valid continuously, RF ready → grants alternate 0,1,0,1; one write per cycle.
- Backpressure: RF ready low 3 cycles with entry full → outputs stable, both EU readies 0, no release, `perf_stall_o` +3.
- Back-to-back under ready: RF handshake and new EU accept same cycle → next entry valid with no bubble cycle.
- Zero mask: act_mask=0 → write with mask 0, release strobe still asserted once.
- Reset while full → valid 0 next cycle, `rr_q`=0, no release for dropped entry.
